mult_control_n: RTL and testbench

Parameterised control unit for an N-bit add-shift signed multiplier. It is the successor to the 8-bit fixed-count shift controller. It sequences the clear, add/subtract and arithmetic-shift steps over WIDTH iterations, with a subtract on the final iteration for two's-complement correction. It sits beside the X:A:B register chain and adder datapath. It drives one-cycle strobes only and holds no datapath state.

---
 rtl/mult_ctrl_pkg.sv | 18 +
 rtl/iter_counter.sv | 32 +++
 rtl/mult_control_n.sv | 112 +++++++++++
 tb/tb_mult_control_n.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the N-bit add-shift multiplier controller and datapath.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ADD,
        SHIFT,
        DONE,
        HOLD
    } mult_state_t;

    // Width of an iteration index for a w-bit operand.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: synchronous clear, increments on en, saturates at WIDTH-1.
module iter_counter
    import mult_ctrl_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

    // Count register; holds at the terminal value instead of wrapping.
    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            cnt <= '0;
        end else if (en && !last) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Terminal-count flag used for the final-iteration subtract and exit.
    always_comb begin
        last = (cnt == LAST_VAL);
    end

endmodule

// File: rtl/mult_control_n.sv
// Control unit for an N-bit add-shift signed multiplier: sequences clear,
// add/subtract and arithmetic shift strobes over WIDTH iterations.
module mult_control_n
    import mult_ctrl_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             M,
    output logic             Clr_Ld,
    output logic             Clr_XA,
    output logic             Add,
    output logic             Sub,
    output logic             Shift,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Iter
);

    mult_state_t      state_q;
    mult_state_t      state_d;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             cnt_clr;
    logic             cnt_en;

    iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .last  (last)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; Add/Sub and Clr_Ld are Mealy on inputs.
    always_comb begin
        state_d = state_q;
        Clr_Ld  = 1'b0;
        Clr_XA  = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                Clr_Ld = ClearA_LoadB & ~Run;
                if (Run) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                Clr_XA  = 1'b1;
                Busy    = 1'b1;
                cnt_clr = 1'b1;
                state_d = ADD;
            end
            ADD: begin
                Busy    = 1'b1;
                Add     = M & ~last;
                Sub     = M & last;
                state_d = SHIFT;
            end
            SHIFT: begin
                Shift  = 1'b1;
                Busy   = 1'b1;
                cnt_en = ~last;
                if (last) begin
                    state_d = DONE;
                end else begin
                    state_d = ADD;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Debug view of the iteration index.
    always_comb begin
        Iter = cnt;
    end

endmodule

// File: tb/tb_mult_control_n.sv
// Self-checking bench for mult_control_n at WIDTH=8 and WIDTH=16, using a
// cycle-indexed expectation model plus a behavioural X:A:B datapath whose
// final product is compared against plain signed multiplication.
module tb_mult_control_n;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset, CL, M, Run8, Run16;
    logic c8_clrld, c8_clrxa, c8_add, c8_sub, c8_shift, c8_busy, c8_done;
    logic c16_clrld, c16_clrxa, c16_add, c16_sub, c16_shift, c16_busy, c16_done;
    logic [2:0] it8;
    logic [3:0] it16;

    mult_control_n #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Run(Run8), .ClearA_LoadB(CL), .M(M),
        .Clr_Ld(c8_clrld), .Clr_XA(c8_clrxa), .Add(c8_add), .Sub(c8_sub),
        .Shift(c8_shift), .Busy(c8_busy), .Done(c8_done), .Iter(it8)
    );

    mult_control_n #(.WIDTH(16)) dut16 (
        .Clk(Clk), .Reset(Reset), .Run(Run16), .ClearA_LoadB(CL), .M(M),
        .Clr_Ld(c16_clrld), .Clr_XA(c16_clrxa), .Add(c16_add), .Sub(c16_sub),
        .Shift(c16_shift), .Busy(c16_busy), .Done(c16_done), .Iter(it16)
    );

    // Select which instance is under test.
    logic sel;
    logic o_clrld, o_clrxa, o_add, o_sub, o_shift, o_busy, o_done;
    logic [63:0] o_iter;
    always_comb begin
        o_clrld = sel ? c16_clrld : c8_clrld;
        o_clrxa = sel ? c16_clrxa : c8_clrxa;
        o_add   = sel ? c16_add   : c8_add;
        o_sub   = sel ? c16_sub   : c8_sub;
        o_shift = sel ? c16_shift : c8_shift;
        o_busy  = sel ? c16_busy  : c8_busy;
        o_done  = sel ? c16_done  : c8_done;
        o_iter  = sel ? 64'(it16) : 64'(it8);
    end

    int checks = 0;
    int failures = 0;
    int prev_iter [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_run(input logic v);
        if (sel) Run16 = v;
        else     Run8  = v;
    endtask

    function automatic longint sext(input longint v, input int w);
        if (((v >> (w - 1)) & 1) != 0) return v - (longint'(1) << w);
        return v;
    endfunction

    task automatic chk_all(input string tag, input logic e_clrld, input logic e_clrxa,
                           input logic e_add, input logic e_sub, input logic e_shift,
                           input logic e_busy, input logic e_done, input int e_iter);
        chk({tag, "_clrld"}, 64'(o_clrld), 64'(e_clrld));
        chk({tag, "_clrxa"}, 64'(o_clrxa), 64'(e_clrxa));
        chk({tag, "_add"},   64'(o_add),   64'(e_add));
        chk({tag, "_sub"},   64'(o_sub),   64'(e_sub));
        chk({tag, "_shift"}, 64'(o_shift), 64'(e_shift));
        chk({tag, "_busy"},  64'(o_busy),  64'(e_busy));
        chk({tag, "_done"},  64'(o_done),  64'(e_done));
        chk({tag, "_iter"},  o_iter,       64'(e_iter));
    endtask

    // One multiplication a*b on the selected instance. reset_at >= 0 aborts
    // the run with Reset in that cycle index (0 = CLEAR cycle).
    task automatic run_mult(input longint a, input longint b, input bit cl_with_run,
                            input int hold_cycles, input int reset_at);
        int W;
        longint mask, av, bv, A, B, X, r, p;
        int n_add, n_sub, n_shift, n_busy, n_done, i;
        bit e_add, e_sub, is_add;
        string t;
        W = sel ? 16 : 8;
        mask = (longint'(1) << W) - 1;
        av = a & mask;
        bv = b & mask;
        n_add = 0; n_sub = 0; n_shift = 0; n_busy = 0; n_done = 0;

        // Load B / clear A request honoured in IDLE.
        set_run(1'b0);
        CL = 1'b1;
        #1;
        chk("idle_load_clrld", 64'(o_clrld), 64'd1);
        tick();
        A = 0; X = 0; B = bv;

        // Start; Run dominates a simultaneous load request.
        CL = cl_with_run;
        set_run(1'b1);
        #1;
        chk("idle_start_clrld", 64'(o_clrld), 64'd0);

        for (int k = 0; k <= 2 * W + 1; k++) begin
            tick();
            is_add = (k % 2 == 1) && (k <= 2 * W);
            i = (k - 1) / 2;
            // M is only meaningful in ADD cycles; scramble it elsewhere.
            if (is_add) M = logic'(B & 1);
            else        M = logic'($urandom_range(0, 1));
            CL = logic'($urandom_range(0, 1));
            #1;
            e_add = is_add && (((bv >> i) & 1) != 0) && (i < W - 1);
            e_sub = is_add && (((bv >> i) & 1) != 0) && (i == W - 1);
            t = $sformatf("w%0d_k%0d", W, k);
            chk_all(t, 1'b0, k == 0, e_add, e_sub, (k >= 2) && (k <= 2 * W) && (k % 2 == 0),
                    k <= 2 * W, k == 2 * W + 1,
                    (k == 0) ? prev_iter[sel] : ((i < W - 1) ? i : W - 1));
            n_add   += int'(o_add);
            n_sub   += int'(o_sub);
            n_shift += int'(o_shift);
            n_busy  += int'(o_busy);
            n_done  += int'(o_done);
            // Behavioural datapath reacting to the observed strobes.
            if (o_clrxa) begin A = 0; X = 0; end
            if (o_add || o_sub) begin
                r = o_add ? sext(A, W) + sext(av, W) : sext(A, W) - sext(av, W);
                A = r & mask;
                X = (r >> W) & 1;
            end
            if (o_shift) begin
                B = (B >> 1) | ((A & 1) << (W - 1));
                A = (A >> 1) | (X << (W - 1));
            end
            if (k == reset_at) begin
                Reset = 1'b1;
                set_run(1'b0);
                CL = 1'b0;
                tick();
                Reset = 1'b0;
                #1;
                chk_all($sformatf("w%0d_rst", W), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
                for (int q = 0; q < 3; q++) begin
                    tick();
                    M = logic'($urandom_range(0, 1));
                    #1;
                    chk_all($sformatf("w%0d_postrst%0d", W, q), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 0);
                end
                prev_iter[sel] = 0;
                return;
            end
        end

        chk("count_add",   64'(n_add),   64'($countones(bv & (mask >> 1))));
        chk("count_sub",   64'(n_sub),   64'((bv >> (W - 1)) & 1));
        chk("count_shift", 64'(n_shift), 64'(W));
        chk("count_busy",  64'(n_busy),  64'(2 * W + 1));
        chk("count_done",  64'(n_done),  64'd1);
        p = (A << W) | B;
        if (((p >> (2 * W - 1)) & 1) != 0) p = p - (longint'(1) << (2 * W));
        chk($sformatf("product_w%0d", W), 64'(p), 64'(sext(av, W) * sext(bv, W)));
        prev_iter[sel] = W - 1;

        // Run held high: stays quiet in HOLD.
        for (int h = 0; h < hold_cycles; h++) begin
            tick();
            CL = logic'($urandom_range(0, 1));
            M  = logic'($urandom_range(0, 1));
            #1;
            chk_all($sformatf("w%0d_hold%0d", W, h), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    W - 1);
        end
        set_run(1'b0);
        CL = 1'b0;
        tick();
        CL = 1'b1;
        #1;
        chk_all($sformatf("w%0d_back_idle", W), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W - 1);
        CL = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; CL = 1'b0; M = 1'b0; Run8 = 1'b0; Run16 = 1'b0; sel = 1'b0;
        prev_iter[0] = 0;
        prev_iter[1] = 0;
        tick();
        tick();
        Reset = 1'b0;

        // Reset state with load request pending.
        CL = 1'b1;
        #1;
        chk_all("reset8", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        sel = 1'b1;
        #1;
        chk_all("reset16", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        sel = 1'b0;
        CL = 1'b0;
        #1;
        chk("reset8_clrld_low", 64'(o_clrld), 64'd0);

        // WIDTH=8 directed runs.
        run_mult(longint'($urandom), -1, 1'b0, 3, -1);
        run_mult(longint'($urandom), 0, 1'b0, 20, -1);
        run_mult(longint'($urandom), longint'($urandom), 1'b0, 2, 8);
        run_mult(longint'($urandom), longint'($urandom), 1'b1, 2, -1);
        run_mult(-128, -128, 1'b0, 1, -1);
        for (int n = 0; n < 6; n++)
            run_mult(longint'($urandom), longint'($urandom), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 4), -1);

        // WIDTH=16 runs.
        sel = 1'b1;
        run_mult(longint'($urandom), 64'hAAAA, 1'b0, 2, -1);
        run_mult(-32768, -32768, 1'b0, 1, -1);
        run_mult(longint'($urandom), longint'($urandom), 1'b0, 1, 5);
        for (int n = 0; n < 4; n++)
            run_mult(longint'($urandom), longint'($urandom), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 4), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
